// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment codes, helpers and scan state encoding.
// Used by seg7_scan and by the stopwatch digit encoders.
package seg7_pkg;

   localparam logic [6:0] SEG7_ZERO = 7'h3F;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_e;

   // BCD digit to active-high segments, bit 0 = segment a
   function automatic logic [6:0] seg7(input logic [3:0] bcd);
      logic [6:0] s;
      case (bcd)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment scanner with per-slot blanking,
// 16-level PWM brightness, leading-zero blanking and frame snapshots.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int DGN     = 4,
   parameter int SLN     = 1024,
   parameter int SLL     = $clog2(SLN),
   parameter int BLN     = 8,
   parameter bit SEG_INV = 1'b1,
   parameter bit DIG_INV = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [7*DGN-1:0] seg_i,
   input  logic [DGN-1:0]   dp_i,
   input  logic [3:0]       bright,
   input  logic             lzb,
   output logic [6:0]       seg_o,
   output logic             dp_o,
   output logic [DGN-1:0]   an_o,
   output logic             frame_o
);

   localparam int DGL = (DGN > 1) ? $clog2(DGN) : 1;

   state_e               state_q, state_d;
   logic [SLL-1:0]       cnt_q, cnt_d;
   logic [DGL-1:0]       dig_q, dig_d;
   logic [DGN-1:0][6:0]  hseg_q, hseg_d;
   logic [DGN-1:0]       hdp_q, hdp_d;
   logic                 hlzb_q, hlzb_d;
   logic [6:0]           seg_q, seg_d;
   logic                 dp_q, dp_d;
   logic [DGN-1:0]       an_q, an_d;
   logic                 frame_q, frame_d;

   logic                 run, snap, lit, on, zrun;
   logic [DGN-1:0]       supp;

   assign run  = (state_q == ST_SCAN) && en;
   assign snap = run && (cnt_q == '0) && (dig_q == '0);

   // scan FSM next state; en low leaves SCAN in any cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en)  state_d = ST_SCAN;
         ST_SCAN: if (!en) state_d = ST_IDLE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // slot counter and digit index; both held at zero outside SCAN
   always_comb begin
      cnt_d = '0;
      dig_d = '0;
      if (run) begin
         cnt_d = cnt_q + 1'b1;
         dig_d = dig_q;
         if (cnt_q == SLL'(SLN - 1)) begin
            dig_d = (dig_q == DGL'(DGN - 1)) ? '0 : dig_q + 1'b1;
         end
      end
   end

   // frame snapshot, bypassed so the capture cycle already decodes it
   always_comb begin
      hseg_d = hseg_q;
      hdp_d  = hdp_q;
      hlzb_d = hlzb_q;
      if (snap) begin
         hseg_d = seg_i;
         hdp_d  = dp_i;
         hlzb_d = lzb;
      end
   end

   // leading-zero suppression, scanning down from the top digit
   always_comb begin
      supp = '0;
      zrun = hlzb_d;
      for (int k = DGN - 1; k >= 1; k--) begin
         zrun    = zrun && (hseg_d[k] == SEG7_ZERO);
         supp[k] = zrun;
      end
   end

   // decode of the current slot into pre-register outputs
   always_comb begin
      lit     = run && !supp[dig_q];
      on      = lit && (cnt_q >= SLL'(BLN))
                    && (cnt_q[SLL-1:SLL-4] < bright);
      an_d    = '0;
      if (on) an_d[dig_q] = 1'b1;
      seg_d   = lit ? hseg_d[dig_q] : 7'h00;
      dp_d    = lit & hdp_d[dig_q];
      frame_d = snap;
   end

   // state, counters and hold registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dig_q   <= '0;
         hseg_q  <= '0;
         hdp_q   <= '0;
         hlzb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         hseg_q  <= hseg_d;
         hdp_q   <= hdp_d;
         hlzb_q  <= hlzb_d;
      end
   end

   // output register stage; pin polarity applied only here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q   <= {7{SEG_INV}};
         dp_q    <= SEG_INV;
         an_q    <= {DGN{DIG_INV}};
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_d ^ {7{SEG_INV}};
         dp_q    <= dp_d ^ SEG_INV;
         an_q    <= an_d ^ {DGN{DIG_INV}};
         frame_q <= frame_d;
      end
   end

   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed scenarios for seg7_scan with SLN=64, BLN=2
// and inverted pins; expected waveforms are built per frame cycle.
module tb_seg7_scan;

   localparam int DGN = 4;
   localparam int SLN = 64;
   localparam int BLN = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [27:0] seg_i;
   logic [3:0]  dp_i;
   logic [3:0]  bright;
   logic        lzb;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  an_o;
   logic        frame_o;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   localparam logic [27:0] CODE_A = {7'h06, 7'h5B, 7'h4F, 7'h66};
   localparam logic [27:0] CODE_B = {7'h6D, 7'h7D, 7'h07, 7'h7F};
   localparam logic [27:0] CODE_Z = {7'h3F, 7'h3F, 7'h06, 7'h3F};

   seg7_scan #(
      .DGN(DGN), .SLN(SLN), .BLN(BLN),
      .SEG_INV(1'b1), .DIG_INV(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .seg_i(seg_i), .dp_i(dp_i), .bright(bright), .lzb(lzb),
      .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
   );

   always #5 clk = ~clk;

   // frame cycle g=1 is the sample where frame_o is high
   task automatic check_span(input logic [27:0] codes,
                             input logic [3:0] lit,
                             input logic [3:0] dps,
                             input logic [3:0] br,
                             input int gfrom);
      int bad [4];
      int fst [4];
      logic [3:0] fan [4];
      logic [3:0] xan [4];
      logic [3:0] ean;
      logic [6:0] eseg;
      logic       edp, efr;
      int         d, r;
      for (int i = 0; i < 4; i++) begin
         bad[i] = 0; fst[i] = 0; fan[i] = '0; xan[i] = '0;
      end
      for (int g = gfrom; g <= 256; g++) begin
         if (g != gfrom) @(negedge clk);
         d    = (g - 1) / SLN;
         r    = g - d * SLN;
         ean  = (lit[d] && r >= BLN + 1 && r <= int'(br) * 4)
                ? 4'(1 << d) : 4'h0;
         eseg = lit[d] ? codes[d*7 +: 7] : 7'h00;
         edp  = lit[d] & dps[d];
         efr  = (g == 1);
         if (an_o !== ~ean || seg_o !== ~eseg ||
             dp_o !== ~edp || frame_o !== efr) begin
            if (bad[d] == 0) begin
               fst[d] = g; fan[d] = an_o; xan[d] = ~ean;
            end
            bad[d]++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if ((i + 1) * SLN >= gfrom) begin
            tot_cnt++;
            if (bad[i] != 0)
               $display("FAIL slot%0d: %0d bad cycles (need 0), first g=%0d an=%h need %h",
                        i, bad[i], fst[i], fan[i], xan[i]);
            else
               pass_cnt++;
         end
      end
   endtask

   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         if (frame_o === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         tot_cnt++;
         $display("FAIL frame_timeout: frame_o=%b need 1 within 600 cycles",
                  frame_o);
      end
   endtask

   task automatic check_frame(input logic [27:0] codes,
                              input logic [3:0] lit,
                              input logic [3:0] dps,
                              input logic [3:0] br);
      bit ok;
      wait_frame(ok);
      if (ok) check_span(codes, lit, dps, br, 1);
   endtask

   task automatic check_idle(input string nm);
      tot_cnt++;
      if (an_o !== 4'hF || seg_o !== 7'h7F ||
          dp_o !== 1'b1 || frame_o !== 1'b0)
         $display("FAIL %s: an=%h seg=%h dp=%b fr=%b need F 7f 1 0",
                  nm, an_o, seg_o, dp_o, frame_o);
      else
         pass_cnt++;
   endtask

   task automatic check_fr(input string nm, input logic exp);
      tot_cnt++;
      if (frame_o !== exp)
         $display("FAIL %s: frame_o=%b need %b", nm, frame_o, exp);
      else
         pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; seg_i = CODE_A;
      dp_i = 4'b0101; bright = 4'd15; lzb = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_idle("idle_en0");
   endtask

   task automatic test_scan();
      en = 1'b1;
      @(negedge clk);
      check_fr("start_lat0", 1'b0);
      @(negedge clk);
      check_fr("start_lat1", 1'b1);
      check_span(CODE_A, 4'hF, 4'b0101, 4'd15, 1);
      @(negedge clk);
      check_fr("frame_period", 1'b1);
      check_span(CODE_A, 4'hF, 4'b0101, 4'd15, 1);
   endtask

   task automatic test_bright();
      logic [3:0] lv [3];
      lv[0] = 4'd0; lv[1] = 4'd1; lv[2] = 4'd8;
      for (int i = 0; i < 3; i++) begin
         bright = lv[i];
         check_frame(CODE_A, 4'hF, 4'b0101, lv[i]);
      end
      bright = 4'd15;
   endtask

   task automatic test_lzb();
      seg_i = CODE_Z; lzb = 1'b1;
      check_frame(CODE_Z, 4'b0011, 4'b0101, 4'd15);
      lzb = 1'b0;
      check_frame(CODE_Z, 4'hF, 4'b0101, 4'd15);
   endtask

   task automatic test_snapshot();
      bit ok;
      seg_i = CODE_A;
      check_frame(CODE_A, 4'hF, 4'b0101, 4'd15);
      wait_frame(ok);
      if (ok) begin
         repeat (99) @(negedge clk);
         seg_i = CODE_B;
         check_span(CODE_A, 4'hF, 4'b0101, 4'd15, 100);
      end
      check_frame(CODE_B, 4'hF, 4'b0101, 4'd15);
   endtask

   task automatic test_en_drop();
      bit ok;
      wait_frame(ok);
      if (ok) begin
         repeat (149) @(negedge clk);
         en = 1'b0;
         @(negedge clk);
         check_idle("en_drop");
         repeat (9) @(negedge clk);
         check_idle("en_low");
         en = 1'b1;
         @(negedge clk);
         check_idle("en_rise");
         @(negedge clk);
         check_fr("restart_frame", 1'b1);
         check_span(CODE_B, 4'hF, 4'b0101, 4'd15, 1);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      wait_frame(ok);
      if (ok) begin
         repeat (70) @(negedge clk);
         tot_cnt++;
         if (an_o !== 4'b1101)
            $display("FAIL pre_rst_an: an=%h need d", an_o);
         else
            pass_cnt++;
         #2 rst_n = 1'b0;
         #1 check_idle("async_rst");
         @(negedge clk);
         check_idle("rst_held");
         rst_n = 1'b1;
         @(negedge clk);
         check_fr("rst_rel0", 1'b0);
         @(negedge clk);
         check_fr("rst_rel1", 1'b1);
         check_span(CODE_B, 4'hF, 4'b0101, 4'd15, 1);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_bright();
      test_lzb();
      test_snapshot();
      test_en_drop();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
